// File: rtl/time_entry_if.sv
// time_entry_if: digit-entry inputs, commit/error status and the load handshake toward the time-keeping core
interface time_entry_if;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clear;
    logic        commit;
    logic [3:0]  digit_cnt;
    logic        bad_digit;
    logic        err;
    logic        load_valid;
    logic        load_ready;
    logic [12:0] year;
    logic [3:0]  mont;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    modport master (
        output digit_valid, digit, clear, commit, load_ready,
        input  digit_cnt, bad_digit, err, load_valid, year, mont, day, hour, min, sec
    );
    modport slave (
        input  digit_valid, digit, clear, commit, load_ready,
        output digit_cnt, bad_digit, err, load_valid, year, mont, day, hour, min, sec
    );
endinterface

// File: rtl/time_entry.sv
// time_entry: assembles typed BCD digits into a binary date/time, validates it and offers it for loading
module time_entry #(
    parameter int YEAR_MIN = 1900,
    parameter int YEAR_MAX = 2099
) (
    input logic         clk,
    input logic         rst,
    time_entry_if.slave bus
);
    typedef enum logic [1:0] {ENTRY, CHECK, JUDGE, OFFER} state_t;

    localparam logic [13:0] Y_LO = 14'(YEAR_MIN);
    localparam logic [13:0] Y_HI = 14'(YEAR_MAX);

    state_t      state, next;
    logic [3:0]  cnt;
    logic [13:0] yacc, ymac;
    logic [6:0]  macc, dacc, hacc, nacc, sacc;
    logic [3:0]  ydig [4];
    logic        ok, bad_r, err_r;
    logic        in_entry, full, take, bad, early, reject, wipe;
    logic [6:0]  y2, c2, dim;
    logic        leap, valid;

    function automatic logic [6:0] mac7(input logic [6:0] x, input logic [3:0] d);
        return {x[3:0], 3'b0} + {x[5:0], 1'b0} + {3'b0, d};
    endfunction

    // Validity of the assembled fields; the leap test works on the stored year digits so no divider is needed
    always_comb begin
        ymac  = {yacc[10:0], 3'b0} + {yacc[12:0], 1'b0} + {10'b0, bus.digit};
        y2    = mac7({3'b0, ydig[2]}, ydig[3]);
        c2    = mac7({3'b0, ydig[0]}, ydig[1]);
        leap  = (y2[1:0] == 2'b0 && y2 != 7'd0) || (y2 == 7'd0 && c2[1:0] == 2'b0);
        dim   = macc == 7'd2 ? (leap ? 7'd29 : 7'd28) :
                (macc == 7'd4 || macc == 7'd6 || macc == 7'd9 || macc == 7'd11) ? 7'd30 : 7'd31;
        valid = yacc >= Y_LO && yacc <= Y_HI && macc >= 7'd1 && macc <= 7'd12 &&
                dacc >= 7'd1 && dacc <= dim && hacc <= 7'd23 && nacc <= 7'd59 && sacc <= 7'd59;
    end

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? ENTRY : next;
    end

    // Next state: a digit or clear in the same cycle as commit takes precedence over it
    always_comb begin
        next = state;
        case (state)
            ENTRY:   next = (!bus.clear && !bus.digit_valid && bus.commit && full) ? CHECK : ENTRY;
            CHECK:   next = JUDGE;
            JUDGE:   next = ok ? OFFER : ENTRY;
            OFFER:   next = (bus.clear || bus.load_ready) ? ENTRY : OFFER;
            default: next = ENTRY;
        endcase
    end

    // Control decodes for the datapath; inputs other than clear are only honoured in ENTRY
    always_comb begin
        in_entry = state == ENTRY;
        full     = cnt == 4'd14;
        take     = in_entry && !bus.clear && bus.digit_valid && bus.digit <= 4'd9 && !full;
        bad      = in_entry && !bus.clear && bus.digit_valid && bus.digit > 4'd9;
        early    = in_entry && !bus.clear && !bus.digit_valid && bus.commit && !full;
        reject   = state == JUDGE && !ok;
        wipe     = (in_entry && bus.clear) || early || reject ||
                   (state == OFFER && (bus.clear || bus.load_ready));
    end

    // Field accumulators, status pulses and the registered validity flag
    always_ff @(posedge clk) begin
        bad_r <= !rst && bad;
        err_r <= !rst && (early || reject);
        ok    <= !rst && valid;
        if (rst || wipe) begin
            cnt  <= 4'd0;
            yacc <= 14'd0;
            macc <= 7'd0;
            dacc <= 7'd0;
            hacc <= 7'd0;
            nacc <= 7'd0;
            sacc <= 7'd0;
            ydig <= '{default: 4'd0};
        end else if (take) begin
            cnt <= cnt + 4'd1;
            if (cnt < 4'd4) begin
                yacc             <= ymac;
                ydig[cnt[1:0]]   <= bus.digit;
            end else if (cnt < 4'd6)  macc <= mac7(macc, bus.digit);
            else if (cnt < 4'd8)  dacc <= mac7(dacc, bus.digit);
            else if (cnt < 4'd10) hacc <= mac7(hacc, bus.digit);
            else if (cnt < 4'd12) nacc <= mac7(nacc, bus.digit);
            else                  sacc <= mac7(sacc, bus.digit);
        end
    end

    assign bus.digit_cnt  = cnt;
    assign bus.bad_digit  = bad_r;
    assign bus.err        = err_r;
    assign bus.load_valid = state == OFFER;
    assign bus.year       = yacc[12:0];
    assign bus.mont       = macc[3:0];
    assign bus.day        = dacc[4:0];
    assign bus.hour       = hacc[4:0];
    assign bus.min        = nacc[5:0];
    assign bus.sec        = sacc[5:0];
endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: randomized and directed stimulus checked every cycle against a decimal-level model
module tb_time_entry;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_entry_if bus();
    time_entry #(.YEAR_MIN(1900), .YEAR_MAX(2099)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errs = 0;
    int checks = 0;
    int m_cnt;
    int m_dig [14];
    bit m_bad, m_err;
    int m_ph;
    int dim_t [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int val(input int lo, input int n);
        int v = 0;
        for (int i = lo; i < lo + n; i++) if (i < m_cnt) v = v * 10 + m_dig[i];
        return v;
    endfunction

    function automatic bit date_ok();
        int y = val(0, 4);
        int mo = val(4, 2);
        int d = val(6, 2);
        bit leap = (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
        int days;
        if (mo < 1 || mo > 12) return 0;
        days = dim_t[mo] + ((mo == 2 && leap) ? 1 : 0);
        return y >= 1900 && y <= 2099 && d >= 1 && d <= days &&
               val(8, 2) <= 23 && val(10, 2) <= 59 && val(12, 2) <= 59;
    endfunction

    task automatic wipe();
        m_cnt = 0;
        for (int i = 0; i < 14; i++) m_dig[i] = 0;
    endtask

    // m_ph: 0 entry, 1 and 2 the two cycles before the decision is visible, 3 offering
    task automatic model(input bit r, input bit dv, input int d, input bit cl, input bit cm, input bit lr);
        m_bad = 0;
        m_err = 0;
        if (r) begin
            wipe();
            m_ph = 0;
        end else if (m_ph == 0) begin
            if (cl) wipe();
            else if (dv) begin
                if (d > 9) m_bad = 1;
                else if (m_cnt < 14) begin
                    m_dig[m_cnt] = d;
                    m_cnt++;
                end
            end else if (cm) begin
                if (m_cnt == 14) m_ph = 1;
                else begin
                    m_err = 1;
                    wipe();
                end
            end
        end else if (m_ph == 1) m_ph = 2;
        else if (m_ph == 2) begin
            if (date_ok()) m_ph = 3;
            else begin
                m_err = 1;
                wipe();
                m_ph = 0;
            end
        end else if (cl || lr) begin
            wipe();
            m_ph = 0;
        end
    endtask

    task automatic compare();
        chk("digit_cnt", bus.digit_cnt, m_cnt);
        chk("bad_digit", bus.bad_digit, m_bad);
        chk("err", bus.err, m_err);
        chk("load_valid", bus.load_valid, m_ph == 3);
        chk("year", bus.year, val(0, 4) % 8192);
        chk("mont", bus.mont, val(4, 2) % 16);
        chk("day", bus.day, val(6, 2) % 32);
        chk("hour", bus.hour, val(8, 2) % 32);
        chk("min", bus.min, val(10, 2) % 64);
        chk("sec", bus.sec, val(12, 2) % 64);
    endtask

    task automatic cyc(input bit r, input bit dv, input int d, input bit cl, input bit cm, input bit lr);
        rst = r;
        bus.digit_valid = dv;
        bus.digit = 4'(d);
        bus.clear = cl;
        bus.commit = cm;
        bus.load_ready = lr;
        model(r, dv, d, cl, cm, lr);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n, input bit lr = 0);
        repeat (n) cyc(0, 0, 0, 0, 0, lr);
    endtask

    task automatic type_num(input int y, input int mo, input int d, input int h, input int mi, input int s);
        int q [14];
        q = '{y / 1000 % 10, y / 100 % 10, y / 10 % 10, y % 10, mo / 10, mo % 10,
              d / 10, d % 10, h / 10, h % 10, mi / 10, mi % 10, s / 10, s % 10};
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            cyc(0, 1, q[i], 0, 0, 0);
        end
    endtask

    task automatic entry_case(input int y, input int mo, input int d, input int h, input int mi, input int s,
                              input int stall);
        type_num(y, mo, d, h, mi, s);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);
        idle(stall);
        idle(1, 1);
        idle(1);
    endtask

    initial begin
        bus.digit_valid = 0;
        bus.digit = 0;
        bus.clear = 0;
        bus.commit = 0;
        bus.load_ready = 0;
        wipe();
        m_ph = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 1, 1);
        chk("lit_reset_cnt", bus.digit_cnt, 0);
        chk("lit_reset_lv", bus.load_valid, 0);

        type_num(2024, 2, 29, 23, 59, 58);
        cyc(0, 0, 0, 0, 1, 0);
        idle(1);
        chk("lit_no_lv_T1", bus.load_valid, 0);
        idle(1);
        chk("lit_lv", bus.load_valid, 1);
        chk("lit_year", bus.year, 2024);
        chk("lit_mont", bus.mont, 2);
        chk("lit_day", bus.day, 29);
        chk("lit_hour", bus.hour, 23);
        chk("lit_min", bus.min, 59);
        chk("lit_sec", bus.sec, 58);
        idle(1, 1);
        chk("lit_cnt_after_load", bus.digit_cnt, 0);
        chk("lit_lv_drop", bus.load_valid, 0);

        type_num(2023, 2, 29, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);
        chk("lit_err_2023", bus.err, 1);
        chk("lit_no_lv_2023", bus.load_valid, 0);
        idle(1);
        chk("lit_err_pulse", bus.err, 0);

        entry_case(1900, 2, 29, 0, 0, 0, 1);
        entry_case(2000, 2, 29, 12, 0, 0, 1);
        entry_case(2100, 1, 1, 0, 0, 0, 1);
        entry_case(2024, 13, 1, 0, 0, 0, 1);
        entry_case(2024, 4, 31, 0, 0, 0, 1);
        entry_case(2024, 4, 30, 24, 0, 0, 1);
        entry_case(2024, 4, 30, 0, 0, 0, 1);
        entry_case(2099, 12, 31, 23, 59, 59, 20);

        for (int i = 0; i < 5; i++) cyc(0, 1, i + 1, 0, 0, 0);
        cyc(0, 1, 10, 0, 0, 0);
        chk("lit_bad_digit", bus.bad_digit, 1);
        chk("lit_bad_cnt", bus.digit_cnt, 5);
        for (int i = 0; i < 5; i++) cyc(0, 1, i, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_early_err", bus.err, 1);
        chk("lit_early_cnt", bus.digit_cnt, 0);

        for (int i = 0; i < 3; i++) cyc(0, 1, 7, 0, 0, 0);
        cyc(0, 1, 7, 1, 0, 0);
        chk("lit_clear_digit", bus.digit_cnt, 0);

        type_num(2024, 2, 29, 23, 59, 58);
        cyc(0, 0, 0, 0, 1, 0);
        idle(4);
        cyc(1, 0, 0, 0, 0, 0);
        chk("lit_rst_offer_lv", bus.load_valid, 0);
        chk("lit_rst_offer_year", bus.year, 0);
        idle(1);

        for (int k = 0; k < 30; k++) begin
            int yr;
            yr = ($urandom_range(0, 3) == 0) ? (1900 + 100 * $urandom_range(0, 2)) : $urandom_range(1890, 2110);
            entry_case(yr, $urandom_range(0, 13), $urandom_range(0, 32), $urandom_range(0, 25),
                       $urandom_range(0, 61), $urandom_range(0, 61), $urandom_range(0, 4));
        end

        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 11),
                $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/time_entry.md
Name: time_entry

Overview:
- Reverse path of the clock's digit display: accepts decimal digits typed by the user (one BCD digit per strobe) and assembles them into binary year/month/day/hour/minute/second fields.
- On a commit request it validates the date and time, including days-per-month and the Gregorian leap rule.
- A valid date/time is offered to the time-keeping counters over a valid/ready load handshake. An invalid entry produces a one-cycle error pulse.

Parameters:
- YEAR_MIN, 1900, smallest year accepted on commit.
- YEAR_MAX, 2099, largest year accepted on commit; must be ≤ 8191 so it fits 13 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_valid  in  1  one-cycle strobe: digit is presented
- digit  in  4  BCD digit, legal values 0..9
- clear  in  1  discard the entry in progress
- commit  in  1  request validation and load
- digit_cnt  out  4  number of digits accepted so far, 0..14 (display cursor)
- bad_digit  out  1  one-cycle pulse: a digit >9 was rejected
- err  out  1  one-cycle pulse: commit was rejected
- load_valid  out  1  assembled value is offered
- load_ready  in  1  time-keeping core accepts the offer
- year  out  13  binary year
- mont  out  4  binary month
- day  out  5  binary day
- hour  out  5  binary hour
- min  out  6  binary minute
- sec  out  6  binary second

Behaviour:
- Reset: state=ENTRY; digit_cnt=0; all field registers=0; bad_digit=err=load_valid=0.
- Digit order is fixed as Y Y Y Y M M D D h h m m s s (most significant first). digit_cnt selects the destination field.
- Accumulation: field ← field*10 + digit, using the shift-add form x*8 + x*2 + d; no dividers anywhere.
  - Year uses a 14-bit internal accumulator; the year output is its low 13 bits.
  - The two-digit fields use 7-bit accumulators, truncated to the port width.
  - The four year BCD digits are also stored separately for the leap test.
- ENTRY state, per cycle, by priority:
  1. clear: digit_cnt←0 and all fields←0.
  2. digit_valid with digit>9: bad_digit=1 next cycle; nothing stored.
  3. digit_valid with digit≤9 and digit_cnt<14: store the digit; digit_cnt+1.
  4. digit_valid with digit_cnt==14: ignored silently.
  5. commit with digit_cnt==14: go to CHECK.
  6. commit with digit_cnt<14: err=1 next cycle, then clear as in 1.
- If digit_valid and commit arrive in the same cycle, the digit wins and commit is ignored.
- CHECK (exactly 1 cycle): registered validity computation. All conditions must hold:
  - YEAR_MIN ≤ year ≤ YEAR_MAX
  - 1 ≤ mont ≤ 12
  - 1 ≤ day ≤ dim
  - hour ≤ 23, min ≤ 59, sec ≤ 59
- Days in month (dim): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February is 29 if leap, else 28.
- Leap rule, derived from the stored year digits:
  - y2 = tens*10 + ones; c2 = thousands*10 + hundreds.
  - leap = (y2%4==0 and y2≠0) or (y2==0 and c2%4==0).
- Outcome of CHECK:
  - Valid: go to OFFER.
  - Invalid: err=1 for one cycle, clear, return to ENTRY.
- Latency: commit sampled at edge T; CHECK during T..T+1; load_valid or err high from edge T+2.
- OFFER:
  - load_valid=1 and all fields held stable while load_ready=0.
  - On the first cycle with load_ready=1, the transfer completes. At the next edge: load_valid=0, clear, return to ENTRY.
  - digit_valid and commit are ignored in CHECK and OFFER.
  - clear in OFFER drops load_valid at the next edge without a transfer.
- err and bad_digit are never high together with load_valid.
- Reset asserted in any state returns to the reset values at the next edge, even mid-entry or mid-offer.

Test Plan:
- Enter 2,0,2,4,0,2,2,9,2,3,5,9,5,8, then commit, load_ready=1 → at T+2: load_valid=1, year=2024, mont=2, day=29, hour=23, min=59, sec=58. Next cycle: digit_cnt=0.
- Leap rule: 2023-02-29 → err pulse, no load_valid; 1900-02-29 → err; 2000-02-29 → load; 2100-01-01 → err (exceeds YEAR_MAX).
- Range checks: mont=13, then day=31 in April, then hour=24 (each with otherwise valid fields) → err for each; 2024-04-30 00:00:00 → load.
- digit=0xA mid-entry → bad_digit one cycle, digit_cnt unchanged. Commit at digit_cnt=10 → err, digit_cnt=0.
- Backpressure: hold load_ready=0 for 20 cycles → load_valid and fields stable throughout; raise load_ready → exactly one transfer.
- Clear plus digit_valid in the same cycle → digit_cnt=0. Reset asserted during OFFER → load_valid=0 and all fields 0 at the next edge.
